// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// the largest legal BCD digit and a digit clamp helper.
package bcd_countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest legal BCD digit; the score counters use the same limit.
   localparam logic [3:0] BCD_MAX = 4'd9;

   // Force any non-BCD nibble (10..15) down to 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      logic [3:0] r;
      if (v > BCD_MAX) begin
         r = BCD_MAX;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit register that counts down.
// A load takes priority over a decrement. A decrement from 0 wraps to 9
// and raises borrow, which feeds the next-higher digit's decrement input.
module bcd_down_digit
   import bcd_countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       d_dec,
   input  logic       d_ld,
   input  logic [3:0] ld_val,
   output logic [3:0] dig,
   output logic       borrow
);

   logic [3:0] r_dig;

   // Digit register: load, decrement with a 0->9 wrap, or hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dig <= 4'd0;
      end else if (d_ld) begin
         r_dig <= ld_val;
      end else if (d_dec) begin
         r_dig <= (r_dig == 4'd0) ? BCD_MAX : (r_dig - 4'd1);
      end else begin
         r_dig <= r_dig;
      end
   end

   assign dig    = r_dig;
   assign borrow = d_dec && (r_dig == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer for the pong round/serve clock.
// It counts down one step per TICK_DIV clocks while in RUN. When the
// count reaches 00 it raises timeout for exactly one cycle.
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter int TICK_DIV = 50000000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] val_hi,
   input  logic [3:0] val_lo,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] dig1,
   output logic [3:0] dig0,
   output logic       running,
   output logic       timeout
);

   localparam int            PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nxt;
   logic          r_running;
   logic          r_timeout;
   logic          w_timeout_nxt;
   logic          w_tick;
   logic          w_ld;
   logic          w_borrow0;
   logic          w_borrow1;
   logic [3:0]    w_dig1;
   logic [3:0]    w_dig0;
   logic [3:0]    w_ld_hi;
   logic [3:0]    w_ld_lo;
   logic          w_zero;
   logic          w_last_step;

   assign w_ld_hi     = bcd_clamp(val_hi);
   assign w_ld_lo     = bcd_clamp(val_lo);
   assign w_zero      = (w_dig1 == 4'd0) && (w_dig0 == 4'd0);
   assign w_last_step = (w_dig1 == 4'd0) && (w_dig0 == 4'd1);

   bcd_down_digit u_ones (
      .clk    (clk),
      .reset  (reset),
      .d_dec  (w_tick),
      .d_ld   (w_ld),
      .ld_val (w_ld_lo),
      .dig    (w_dig0),
      .borrow (w_borrow0)
   );

   bcd_down_digit u_tens (
      .clk    (clk),
      .reset  (reset),
      .d_dec  (w_borrow0),
      .d_ld   (w_ld),
      .ld_val (w_ld_hi),
      .dig    (w_dig1),
      .borrow (w_borrow1)
   );

   // Next state, prescaler and tick decode. Priority: load > stop > start > tick.
   always_comb begin
      w_state_nxt   = r_state;
      w_presc_nxt   = r_presc;
      w_timeout_nxt = 1'b0;
      w_tick        = 1'b0;
      w_ld          = 1'b0;
      if (load) begin
         w_ld        = 1'b1;
         w_presc_nxt = {PW{1'b0}};
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (stop) begin
                  w_state_nxt = ST_IDLE;
               end else if (start) begin
                  if (w_zero) begin
                     // Starting from 00 skips RUN entirely.
                     w_state_nxt   = ST_DONE;
                     w_timeout_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  // The prescaler holds, so a later start resumes the partial tick.
                  w_state_nxt = ST_IDLE;
               end else if (r_presc == PRESC_LAST) begin
                  w_presc_nxt = {PW{1'b0}};
                  w_tick      = 1'b1;
                  // w_borrow1 means the tens digit would underflow. That cannot
                  // happen in normal operation, so treat it as terminal too.
                  if (w_last_step || w_borrow1) begin
                     w_state_nxt   = ST_DONE;
                     w_timeout_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_presc_nxt = r_presc + {{(PW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, prescaler and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_presc   <= {PW{1'b0}};
         r_running <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_timeout <= w_timeout_nxt;
      end
   end

   assign dig1    = w_dig1;
   assign dig0    = w_dig0;
   assign running = r_running;
   assign timeout = r_timeout;

endmodule
